// File: rtl/capture_sequencer.sv
// capture_sequencer: write-side controller for the DSO sample FIFO.
// Runs in the ADC sample clock domain. It decimates the sample stream,
// sequences one acquisition (pre-trigger fill, trigger wait, post-trigger
// count, done), and reports trigger, completion and overflow status.
// Optional feature: define CAPTURE_AUTO_TRIGGER_EN to add an auto-trigger
// timeout while waiting for the trigger.
module capture_sequencer #(
  parameter int WIDTH      = 8,
  parameter int COUNT_BITS = 16,
  parameter int DECIM_BITS = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ARM,
  input  logic                  ABORT,
  input  logic                  SAMPLE_VALID,
  input  logic [WIDTH-1:0]      SAMPLE_DATA,
  input  logic                  TRIGGER,
  input  logic [DECIM_BITS-1:0] DECIMATION,
  input  logic [COUNT_BITS-1:0] PRE_COUNT,
  input  logic [COUNT_BITS-1:0] POST_COUNT,
`ifdef CAPTURE_AUTO_TRIGGER_EN
  input  logic [COUNT_BITS-1:0] AUTO_TIMEOUT,
  output logic                  AUTO_TRIGGERED,
`endif
  output logic                  FIFO_WR,
  output logic [WIDTH-1:0]      FIFO_WR_DATA,
  input  logic                  FIFO_FULL,
  output logic                  BUSY,
  output logic                  TRIGGERED,
  output logic                  DONE,
  output logic                  OVERFLOW
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT,
    S_POST,
    S_DONE
  } state_t;

  localparam logic [COUNT_BITS-1:0] CNT_ONE = COUNT_BITS'(1);
  localparam logic [DECIM_BITS-1:0] DEC_ONE = DECIM_BITS'(1);

  state_t                state;
  state_t                state_next;
  logic [DECIM_BITS-1:0] dcnt;
  logic [DECIM_BITS-1:0] decim_lat;
  logic [COUNT_BITS-1:0] pre_lat;
  logic [COUNT_BITS-1:0] post_lat;
  logic [COUNT_BITS-1:0] pre_cnt;
  logic [COUNT_BITS-1:0] post_cnt;
  logic [COUNT_BITS-1:0] pre_cnt_inc;
  logic [COUNT_BITS-1:0] post_cnt_inc;
  logic                  arm_go;
  logic                  accept;
  logic                  wr_en;
  logic                  drop;
  logic                  trig_hit;
  logic                  auto_fire;

  assign pre_cnt_inc  = pre_cnt + CNT_ONE;
  assign post_cnt_inc = post_cnt + CNT_ONE;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state decode plus the per-cycle accept/write/trigger strobes.
  always_comb begin
    // NOTE: every signal written here is assigned before any branch, so no path can infer a latch.
    state_next = state;
    BUSY       = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
    DONE       = (state == S_DONE);
    arm_go     = ARM && !ABORT && ((state == S_IDLE) || (state == S_DONE));
    accept     = SAMPLE_VALID && (dcnt == '0) && BUSY && !ABORT;
    wr_en      = accept && !FIFO_FULL;
    drop       = accept && FIFO_FULL;
    trig_hit   = (state == S_WAIT) && wr_en && (TRIGGER || auto_fire);

    unique case (state)
      S_IDLE, S_DONE: if (arm_go) state_next = (PRE_COUNT == '0) ? S_WAIT : S_PRE;
      S_PRE:          if (wr_en && (pre_cnt_inc == pre_lat)) state_next = S_WAIT;
      S_WAIT:         if (trig_hit) state_next = (post_lat <= CNT_ONE) ? S_DONE : S_POST;
      S_POST:         if (wr_en && (post_cnt_inc == post_lat)) state_next = S_DONE;
      default:        state_next = S_IDLE;
    endcase

    if (ABORT) state_next = S_IDLE;
  end

  // Write path, decimator, sample counters and sticky status flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      FIFO_WR      <= 1'b0;
      FIFO_WR_DATA <= '0;
      TRIGGERED    <= 1'b0;
      OVERFLOW     <= 1'b0;
      dcnt         <= '0;
      decim_lat    <= '0;
      pre_lat      <= '0;
      post_lat     <= '0;
      pre_cnt      <= '0;
      post_cnt     <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register here sample pre-edge values.
      FIFO_WR <= wr_en;
      if (wr_en) FIFO_WR_DATA <= SAMPLE_DATA;
      if (SAMPLE_VALID) dcnt <= (dcnt == decim_lat) ? '0 : dcnt + DEC_ONE;
      if (drop) OVERFLOW <= 1'b1;
      if (wr_en && (state == S_PRE))  pre_cnt  <= pre_cnt_inc;
      if (wr_en && (state == S_POST)) post_cnt <= post_cnt_inc;
      if (trig_hit) begin
        TRIGGERED <= 1'b1;
        post_cnt  <= CNT_ONE;
      end
      // A new acquisition restarts everything; later assignments take priority.
      if (arm_go) begin
        dcnt      <= '0;
        decim_lat <= DECIMATION;
        pre_lat   <= PRE_COUNT;
        post_lat  <= POST_COUNT;
        pre_cnt   <= '0;
        post_cnt  <= '0;
        TRIGGERED <= 1'b0;
        OVERFLOW  <= 1'b0;
      end
    end
  end

`ifdef CAPTURE_AUTO_TRIGGER_EN
  logic [COUNT_BITS-1:0] auto_lat;
  logic [COUNT_BITS-1:0] wait_cnt;

  // The timeout fires once the WAIT cycle count reaches a nonzero limit.
  assign auto_fire = (auto_lat != '0) && (wait_cnt == auto_lat);

  // WAIT cycle counter (saturates at the limit) and the auto-trigger flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      auto_lat       <= '0;
      wait_cnt       <= '0;
      AUTO_TRIGGERED <= 1'b0;
    end else begin
      if ((state == S_WAIT) && (wait_cnt != auto_lat)) wait_cnt <= wait_cnt + CNT_ONE;
      if (trig_hit && !TRIGGER) AUTO_TRIGGERED <= 1'b1;
      if (arm_go) begin
        auto_lat       <= AUTO_TIMEOUT;
        wait_cnt       <= '0;
        AUTO_TRIGGERED <= 1'b0;
      end
    end
  end
`else
  assign auto_fire = 1'b0;
`endif

endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer: directed bench for capture_sequencer (default build).
// A transaction-level model tracks the acquisition as "samples still owed"
// counts; a compare process checks all outputs every cycle against it, and
// literal write lists pin the model for the main scenarios.
module tb_capture_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ARM = 1'b0;
  logic        ABORT = 1'b0;
  logic        SAMPLE_VALID = 1'b0;
  logic [7:0]  SAMPLE_DATA = '0;
  logic        TRIGGER = 1'b0;
  logic [7:0]  DECIMATION = '0;
  logic [15:0] PRE_COUNT = '0;
  logic [15:0] POST_COUNT = '0;
  logic        FIFO_WR;
  logic [7:0]  FIFO_WR_DATA;
  logic        FIFO_FULL = 1'b0;
  logic        BUSY;
  logic        TRIGGERED;
  logic        DONE;
  logic        OVERFLOW;

  capture_sequencer #(.WIDTH(8), .COUNT_BITS(16), .DECIM_BITS(8)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .ARM          (ARM),
    .ABORT        (ABORT),
    .SAMPLE_VALID (SAMPLE_VALID),
    .SAMPLE_DATA  (SAMPLE_DATA),
    .TRIGGER      (TRIGGER),
    .DECIMATION   (DECIMATION),
    .PRE_COUNT    (PRE_COUNT),
    .POST_COUNT   (POST_COUNT),
    .FIFO_WR      (FIFO_WR),
    .FIFO_WR_DATA (FIFO_WR_DATA),
    .FIFO_FULL    (FIFO_FULL),
    .BUSY         (BUSY),
    .TRIGGERED    (TRIGGERED),
    .DONE         (DONE),
    .OVERFLOW     (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_en = 1'b0;

  // Expected outputs after the coming clock edge.
  logic       exp_wr, exp_busy, exp_done, exp_trig, exp_ovf;
  logic [7:0] exp_data;

  // Model state: an acquisition is "samples still owed" before / after trigger.
  bit m_active, m_done, m_trig, m_ovf;
  int m_pre_left, m_post_target, m_post_done, m_vcount, m_decim;

  logic [7:0] wlog[$];
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_log(input string name);
    check({name, " write count"}, wlog.size(), exp_q.size());
    for (int i = 0; i < wlog.size() && i < exp_q.size(); i++)
      check($sformatf("%s write %0d", name, i), wlog[i], exp_q[i]);
  endtask

  function automatic void model_update();
    bit sel;
    bit arm_ok;
    if (RST) begin
      m_active = 0; m_done = 0; m_trig = 0; m_ovf = 0;
      m_pre_left = 0; m_post_target = 1; m_post_done = 0; m_vcount = 0; m_decim = 0;
      exp_wr = 0; exp_data = '0;
    end else begin
      arm_ok = ARM && !ABORT && !m_active;
      sel = SAMPLE_VALID && m_active && !ABORT && ((m_vcount % (m_decim + 1)) == 0);
      exp_wr = 0;
      if (ABORT) begin
        m_active = 0;
        m_done   = 0;
      end else if (arm_ok) begin
        m_active      = 1;
        m_done        = 0;
        m_trig        = 0;
        m_ovf         = 0;
        m_decim       = int'(DECIMATION);
        m_pre_left    = int'(PRE_COUNT);
        m_post_target = (POST_COUNT == 0) ? 1 : int'(POST_COUNT);
        m_post_done   = 0;
      end else if (sel) begin
        if (FIFO_FULL) m_ovf = 1;
        else begin
          exp_wr   = 1;
          exp_data = SAMPLE_DATA;
          if (m_pre_left > 0) m_pre_left--;
          else if (!m_trig) begin
            if (TRIGGER) begin
              m_trig      = 1;
              m_post_done = 1;
            end
          end else m_post_done++;
          if (m_trig && m_post_done >= m_post_target) begin
            m_active = 0;
            m_done   = 1;
          end
        end
      end
      if (arm_ok) m_vcount = 0;
      else if (SAMPLE_VALID) m_vcount++;
    end
    exp_busy = m_active;
    exp_done = m_done;
    exp_trig = m_trig;
    exp_ovf  = m_ovf;
  endfunction

  // Per-cycle compare, sampled 2 time units after each rising edge.
  always @(posedge CLK) begin
    #2;
    if (chk_en) begin
      check("FIFO_WR", FIFO_WR, exp_wr);
      check("FIFO_WR_DATA", FIFO_WR_DATA, exp_data);
      check("BUSY", BUSY, exp_busy);
      check("DONE", DONE, exp_done);
      check("TRIGGERED", TRIGGERED, exp_trig);
      check("OVERFLOW", OVERFLOW, exp_ovf);
      if (FIFO_WR) wlog.push_back(FIFO_WR_DATA);
    end
  end

  task automatic do_reset();
    @(negedge CLK);
    RST = 1; ARM = 0; ABORT = 0; SAMPLE_VALID = 0; TRIGGER = 0; FIFO_FULL = 0; SAMPLE_DATA = '0;
    model_update();
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic t,
                      input logic f, input logic a, input logic ab);
    @(negedge CLK);
    RST = 0; SAMPLE_VALID = v; SAMPLE_DATA = d; TRIGGER = t; FIFO_FULL = f; ARM = a; ABORT = ab;
    model_update();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, 0, 0);
  endtask

  initial begin
    logic [7:0] d1[9];
    logic       f3[10];
    d1 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24};
    f3 = '{0, 1, 1, 1, 0, 0, 0, 0, 1, 0};

    do_reset();
    chk_en = 1;
    do_reset();
    idle(1);
    check("reset FIFO_WR", FIFO_WR, 1'b0);
    check("reset FIFO_WR_DATA", FIFO_WR_DATA, 8'h00);
    check("reset BUSY", BUSY, 1'b0);
    check("reset DONE", DONE, 1'b0);
    check("reset TRIGGERED", TRIGGERED, 1'b0);
    check("reset OVERFLOW", OVERFLOW, 1'b0);

    // Basic capture: PRE=4, POST=3, trigger on 0x20.
    DECIMATION = 0; PRE_COUNT = 4; POST_COUNT = 3;
    wlog.delete();
    step(0, 8'h00, 0, 0, 1, 0);
    foreach (d1[i]) step(1, d1[i], d1[i] == 8'h20, 0, 0, 0);
    idle(2);
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22};
    check_log("basic");
    check("basic DONE", DONE, 1'b1);
    check("basic TRIGGERED", TRIGGERED, 1'b1);
    check("basic OVERFLOW", OVERFLOW, 1'b0);

    // Decimation 1-in-3, trigger held high throughout (ignored in PRE).
    DECIMATION = 2; PRE_COUNT = 2; POST_COUNT = 2;
    wlog.delete();
    step(0, 8'h00, 0, 0, 1, 0);
    for (int i = 0; i < 12; i++) step(1, 8'(i), 1, 0, 0, 0);
    idle(2);
    exp_q = '{8'h00, 8'h03, 8'h06, 8'h09};
    check_log("decim");
    check("decim DONE", DONE, 1'b1);

    // Overflow during PRE=5, then a dropped trigger sample in WAIT.
    DECIMATION = 0; PRE_COUNT = 5; POST_COUNT = 1;
    wlog.delete();
    step(0, 8'h00, 0, 0, 1, 0);
    foreach (f3[i]) step(1, 8'h40 + 8'(i), i >= 8, f3[i], 0, 0);
    idle(2);
    exp_q = '{8'h40, 8'h44, 8'h45, 8'h46, 8'h47, 8'h49};
    check_log("ovf");
    check("ovf OVERFLOW", OVERFLOW, 1'b1);
    check("ovf TRIGGERED", TRIGGERED, 1'b1);
    check("ovf DONE", DONE, 1'b1);

    // Abort in POST after 1 of 4, ARM while busy, ARM+ABORT together, re-arm.
    PRE_COUNT = 2; POST_COUNT = 4;
    step(0, 8'h00, 0, 0, 1, 0);
    step(1, 8'h60, 0, 0, 0, 0);
    step(1, 8'h61, 0, 0, 0, 0);
    step(1, 8'h62, 0, 0, 1, 0);
    step(1, 8'h63, 1, 0, 0, 0);
    step(1, 8'h64, 1, 0, 0, 1);
    idle(1);
    check("abort BUSY", BUSY, 1'b0);
    check("abort DONE", DONE, 1'b0);
    check("abort TRIGGERED kept", TRIGGERED, 1'b1);
    step(0, 8'h00, 0, 0, 1, 1);
    idle(1);
    check("arm+abort BUSY", BUSY, 1'b0);
    step(0, 8'h00, 0, 0, 1, 0);
    idle(1);
    check("rearm TRIGGERED", TRIGGERED, 1'b0);
    check("rearm BUSY", BUSY, 1'b1);
    wlog.delete();
    for (int i = 0; i < 6; i++) step(1, 8'h70 + 8'(i), i == 2, 0, 0, 0);
    idle(2);
    exp_q = '{8'h70, 8'h71, 8'h72, 8'h73, 8'h74, 8'h75};
    check_log("rearm");
    check("rearm DONE", DONE, 1'b1);

    // PRE=0, POST=0: straight to WAIT, the trigger sample is the only write.
    PRE_COUNT = 0; POST_COUNT = 0;
    wlog.delete();
    step(0, 8'h00, 0, 0, 1, 0);
    idle(1);
    check("zero BUSY", BUSY, 1'b1);
    step(1, 8'h80, 1, 0, 0, 0);
    step(1, 8'h81, 1, 0, 0, 0);
    idle(2);
    exp_q = '{8'h80};
    check_log("zero");
    check("zero DONE", DONE, 1'b1);
    check("zero TRIGGERED", TRIGGERED, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
